theta_slice_sequencer: RTL and testbench

Frame-level controller on the driving side of the column-parity (theta) slice encoder. It accepts a 1600-bit state as 64 serial 25-bit slices and presents each slice z, paired with the original slice z-1 (mod 64), to the encoder. It writes the encoder results back in place, then streams the 64 encoded slices out. It sits between the state loader and the downstream permutation stages and owns all encoder sequencing.

---
 rtl/theta_slice_sequencer.sv | 78 +++++++
 tb/tb_theta_slice_sequencer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/theta_slice_sequencer.sv
// theta_slice_sequencer: loads 64 slices, drives the theta slice encoder
// three cycles per slice with the wrap-around neighbour, then drains results.
module theta_slice_sequencer #(
    parameter int NSLICE = 64,
    parameter int ZW     = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [24:0] in_slice,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [24:0] out_slice,
    output logic [24:0] enc_in1,
    output logic [24:0] enc_in2,
    output logic        enc_en,
    input  logic [24:0] enc_result,
    output logic        busy,
    output logic        done
);
    localparam logic [2:0] LOAD    = 3'd0;
    localparam logic [2:0] SETUP   = 3'd1;
    localparam logic [2:0] FIRE    = 3'd2;
    localparam logic [2:0] CAPTURE = 3'd3;
    localparam logic [2:0] DRAIN   = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [ZW-1:0] z_q, z_d;
    logic [24:0]   prev_q, prev_d;
    logic [24:0]   buf_q [NSLICE];
    logic [24:0]   cur;
    logic          last, in_hs, out_hs, cap, run;

    always_comb begin
        cur       = buf_q[z_q];
        last      = z_q == ZW'(NSLICE - 1);
        in_ready  = state_q == LOAD;
        out_valid = state_q == DRAIN;
        cap       = state_q == CAPTURE;
        run       = state_q == SETUP || state_q == FIRE || cap;
        in_hs     = in_valid && in_ready;
        out_hs    = out_valid && out_ready;
        out_slice = out_valid ? cur : 25'd0;
        enc_in1   = run ? cur : 25'd0;
        enc_in2   = run ? prev_q : 25'd0;
        enc_en    = state_q == FIRE || cap;
        busy      = run;
        done      = out_hs && last;
        z_d       = (in_hs || out_hs || cap) ? z_q + ZW'(1) : z_q;
        prev_d    = (in_hs && last) ? in_slice : cap ? cur : prev_q;
        state_d   = (state_q == LOAD)  ? ((in_hs && last) ? SETUP : LOAD) :
                    (state_q == SETUP) ? FIRE :
                    (state_q == FIRE)  ? CAPTURE :
                    cap                ? (last ? DRAIN : SETUP) :
                    (state_q == DRAIN) ? (done ? LOAD : DRAIN) : LOAD;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD;
            z_q     <= '0;
            prev_q  <= '0;
        end else begin
            state_q <= state_d;
            z_q     <= z_d;
            prev_q  <= prev_d;
        end
    end

    // Slice storage needs no reset; results overwrite originals in place.
    always_ff @(posedge clk) begin
        if (in_hs)
            buf_q[z_q] <= in_slice;
        else if (cap)
            buf_q[z_q] <= enc_result;
    end
endmodule

// File: tb/tb_theta_slice_sequencer.sv
// tb_theta_slice_sequencer: directed and random frames against a theta model,
// with the encoder itself modelled combinationally in the bench.
module tb_theta_slice_sequencer;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, out_valid, out_ready;
    logic        enc_en, busy, done;
    logic [24:0] in_slice, out_slice, enc_in1, enc_in2, enc_result;
    logic [24:0] frame [64];
    logic [24:0] expv  [64];
    int          n_cmp = 0, n_err = 0, total_done = 0, rc;

    theta_slice_sequencer #(.NSLICE(64), .ZW(6)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_slice(in_slice), .out_valid(out_valid), .out_ready(out_ready),
        .out_slice(out_slice), .enc_in1(enc_in1), .enc_in2(enc_in2),
        .enc_en(enc_en), .enc_result(enc_result), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [24:0] theta(input logic [24:0] a, input logic [24:0] b);
        logic [4:0]  p1, p2;
        logic [24:0] r;
        for (int x = 0; x < 5; x++) begin
            p1[x] = a[x] ^ a[x+5] ^ a[x+10] ^ a[x+15] ^ a[x+20];
            p2[x] = b[x] ^ b[x+5] ^ b[x+10] ^ b[x+15] ^ b[x+20];
        end
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
                r[5*y+x] = a[5*y+x] ^ p1[(x+4)%5] ^ p2[(x+1)%5];
        return r;
    endfunction

    always_comb enc_result = theta(enc_in1, enc_in2);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rand_frame();
        for (int z = 0; z < 64; z++) frame[z] = 25'($urandom);
        for (int z = 0; z < 64; z++) expv[z] = theta(frame[z], frame[(z+63)%64]);
    endtask

    task automatic clear_frame();
        for (int z = 0; z < 64; z++) begin
            frame[z] = '0;
            expv[z]  = '0;
        end
    endtask

    // Entered and left just after a falling edge.
    task automatic load_frame(input int gap_pct);
        int k = 0, cyc = 0, bad = 0;
        while (k < 64 && cyc < 3000) begin
            if (in_ready !== 1'b1) bad++;
            in_valid = $urandom_range(99) >= gap_pct;
            in_slice = frame[k];
            @(posedge clk);
            if (in_valid) k++;
            cyc++;
            @(negedge clk);
        end
        chk("load_count", k, 64);
        chk("load_ready", bad, 0);
        in_valid = 1'b1;
        in_slice = 25'h1abcdef;
    endtask

    task automatic run_phase(input int abort_at, output int cycles);
        int bad_en = 0, bad_rdy = 0;
        cycles = 0;
        while (busy === 1'b1 && cycles < 400 && cycles != abort_at) begin
            if (enc_en !== (cycles % 3 != 0)) bad_en++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0) bad_rdy++;
            cycles++;
            in_slice = 25'($urandom);
            @(negedge clk);
        end
        chk("run_enc_pattern", bad_en, 0);
        chk("run_ready_low", bad_rdy, 0);
    endtask

    task automatic drain_frame(input int ready_pct);
        int k = 0, cyc = 0, dones = 0, bad_v = 0, bad_hold = 0;
        logic [24:0] held = '0;
        bit stalled = 0;
        in_valid = 1'b0;
        while (k < 64 && cyc < 3000) begin
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0) bad_v++;
            if (stalled && out_slice !== held) bad_hold++;
            if (!stalled) chk($sformatf("slice_%0d", k), out_slice, expv[k]);
            out_ready = $urandom_range(99) < ready_pct;
            #1;
            if (done === 1'b1) dones++;
            held    = out_slice;
            stalled = !out_ready;
            @(posedge clk);
            if (out_ready) k++;
            cyc++;
            @(negedge clk);
        end
        out_ready = 1'b0;
        total_done += dones;
        chk("drain_count", k, 64);
        chk("drain_valid", bad_v, 0);
        chk("drain_hold", bad_hold, 0);
        chk("done_pulses", dones, 1);
        chk("reentry_ready", in_ready, 1);
        chk("reentry_out_valid", out_valid, 0);
        chk("reentry_out_slice", out_slice, 0);
    endtask

    task automatic do_frame(input int gap_pct, input int ready_pct);
        load_frame(gap_pct);
        run_phase(-1, rc);
        chk("run_cycles", rc, 192);
        drain_frame(ready_pct);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_slice = '0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_slice", out_slice, 0);
        chk("rst_enc", {enc_en, busy, done}, 0);
        chk("rst_enc_in", {enc_in1, enc_in2}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        clear_frame();
        do_frame(0, 100);

        clear_frame();
        frame[0] = 25'h0000001;
        expv[0]  = 25'h0210843;
        expv[1]  = 25'h1084210;
        do_frame(0, 100);

        clear_frame();
        frame[63] = 25'h0000001;
        expv[63]  = 25'h0210843;
        expv[0]   = 25'h1084210;
        do_frame(0, 100);

        rand_frame();
        do_frame(50, 50);

        rand_frame();
        load_frame(20);
        run_phase(100, rc);
        chk("abort_enc_en_before", enc_en, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_enc_en", enc_en, 0);
        chk("abort_busy", busy, 0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_in_ready", in_ready, 1);
        rand_frame();
        do_frame(30, 70);

        total_done = 0;
        for (int f = 0; f < 20; f++) begin
            rand_frame();
            do_frame(f % 2 ? 25 : 0, f % 3 ? 60 : 100);
        end
        chk("b2b_done_total", total_done, 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
